// File: rtl/braille_line_out.sv
// braille_line_out: gathers 6-bit braille cells into a display line and shifts it out serially.
// Latency: LINE_CELLS*6*2*CLK_DIV clk of shifting after the last cell of a line is popped, then a 1-clk latch.
// Backpressure: none upstream; a small FIFO absorbs cells during SHIFT, overflow flags any cell dropped while full.
//
// Ports:
//   clk, rst            system clock; asynchronous active-high reset
//   cell_in, cell_valid one braille cell per valid pulse (bit0 = dot1 ... bit5 = dot6)
//   flush               emit the partially filled line, padded with blank cells
//   ready               input FIFO not full
//   sclk, sdo           serial clock/data to the pin drivers; sdo is stable around each sclk rise
//   latch               one-clk strobe after the last bit of a line
//   busy                high while a line is being shifted or latched
//   overflow            sticky: at least one cell was dropped since reset

// sync_fifo: generic synchronous first-word-fall-through FIFO.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
module sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leave the occupancy untouched.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// braille_line_out: line assembler and serial shifter for the refreshable display.
// Latency: latch pulses LINE_CELLS*6*2*CLK_DIV + 1 clk after the pop that completes a line.
// Backpressure: ready = FIFO not full; cells arriving while full are dropped and set overflow.
module braille_line_out #(
  parameter int LINE_CELLS = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] cell_in,
  input  logic       cell_valid,
  input  logic       flush,
  output logic       ready,
  output logic       sclk,
  output logic       sdo,
  output logic       latch,
  output logic       busy,
  output logic       overflow
);

  localparam int NBITS = LINE_CELLS * 6;
  localparam int WR_W  = $clog2(LINE_CELLS + 1);
  localparam int BIT_W = $clog2(NBITS);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(LINE_CELLS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SHIFT,
    LATCH,
    CLEAR
  } state_t;

  state_t state_q;
  state_t state_d;

  // Input FIFO
  logic       fifo_full;
  logic       fifo_empty;
  logic [5:0] fifo_dout;
  logic       push;
  logic       pop;

  // Line assembly
  logic [LINE_CELLS-1:0][5:0] line_q;
  logic [NBITS-1:0]           line_flat;
  logic [WR_W-1:0]            wr_idx;
  logic                       flush_pending;
  logic                       fp_clr;

  // Serializer
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             sclk_q;
  logic             phase_end;
  logic             overflow_q;

  assign push = cell_valid && !fifo_full;

  sync_fifo #(
    .WIDTH(6),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (cell_in),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Cell 0 lands in the top six bits so that the serial order (cell 0 first,
  // bit5 first within a cell) becomes a simple descending walk of one vector.
  always_comb begin
    line_flat = '0;
    for (int i = 0; i < LINE_CELLS; i++) begin
      line_flat[NBITS - 1 - 6 * i -: 6] = line_q[i];
    end
  end

  assign phase_end = (div_cnt == DIV_LAST);

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fp_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = FILL;
        end else if (flush_pending && (wr_idx == '0)) begin
          // Flush of an empty line: nothing to show, just forget it.
          fp_clr = 1'b1;
        end
      end
      FILL: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // Leave on the same edge as the pop that completes the line.
          if (wr_idx == WR_LAST) begin
            state_d = SHIFT;
            fp_clr  = 1'b1;
          end
        end else if (flush_pending) begin
          fp_clr = 1'b1;
          if (wr_idx != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SHIFT: begin
        if (phase_end && sclk_q && (bit_cnt == BIT_LAST)) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        state_d = CLEAR;
      end
      CLEAR: begin
        state_d = fifo_empty ? IDLE : FILL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A new flush request wins over a clear in the same cycle, so a flush that
  // coincides with entry to SHIFT still applies to the following line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pending <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (flush) begin
        flush_pending <= 1'b1;
      end else if (fp_clr) begin
        flush_pending <= 1'b0;
      end
      if (cell_valid && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Line buffer: filled one cell per pop, wiped in CLEAR so unfilled cells
  // of a flushed line go out as blanks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
      wr_idx <= '0;
    end else if (state_q == CLEAR) begin
      line_q <= '0;
      wr_idx <= '0;
    end else if (pop) begin
      for (int i = 0; i < LINE_CELLS; i++) begin
        if (wr_idx == WR_W'(i)) begin
          line_q[i] <= fifo_dout;
        end
      end
      wr_idx <= wr_idx + WR_W'(1);
    end
  end

  // Serializer: each bit spends CLK_DIV cycles with sclk low, then CLK_DIV
  // with sclk high; bit_cnt advances when the high phase ends. Counters sit
  // at zero outside SHIFT so every line starts cleanly at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (state_q == SHIFT) begin
      if (phase_end) begin
        div_cnt <= '0;
        sclk_q  <= !sclk_q;
        if (sclk_q) begin
          bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end else begin
      sclk_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end
  end

  // sdo is decoded from registers that only change at the end of a high
  // phase, so it is settled for the whole low phase before each sclk rise.
  assign sdo      = (state_q == SHIFT) ? line_flat[BIT_LAST - bit_cnt] : 1'b0;
  assign sclk     = sclk_q;
  assign latch    = (state_q == LATCH);
  assign busy     = (state_q == SHIFT) || (state_q == LATCH);
  assign ready    = !fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_braille_line_out.sv
// tb_braille_line_out: directed checks of braille_line_out with LINE_CELLS=8, FIFO_DEPTH=4, CLK_DIV=1.
// A table of whole-line vectors is pushed and its serial stream compared; hand sequences
// cover empty flush, overflow during a shift, reset mid-shift and flush during a shift.
module tb_braille_line_out;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cell_in;
  logic       cell_valid;
  logic       flush;
  logic       ready;
  logic       sclk;
  logic       sdo;
  logic       latch;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  braille_line_out #(
    .LINE_CELLS(8),
    .FIFO_DEPTH(4),
    .CLK_DIV   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cell_in   (cell_in),
    .cell_valid(cell_valid),
    .flush     (flush),
    .ready     (ready),
    .sclk      (sclk),
    .sdo       (sdo),
    .latch     (latch),
    .busy      (busy),
    .overflow  (overflow)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int push_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: everything sampled on the falling edge, away from DUT updates.
  int          rise_cnt = 0;
  int          latch_cnt = 0;
  int          latch_cyc = 0;
  int          busy_cnt = 0;
  int          sclk_bad = 0;
  logic        sclk_prev = 1'b0;
  logic [47:0] cap = '0;

  always @(negedge clk) begin
    if (sclk && !sclk_prev) begin
      rise_cnt++;
      cap = {cap[46:0], sdo};
    end
    sclk_prev = sclk;
    if (latch) begin
      latch_cnt++;
      latch_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (sclk && !busy) sclk_bad++;
  end

  typedef struct {
    string       name;
    logic [47:0] cells;    // cell j at [6*j +: 6]
    int          n;
    bit          fl;       // flush together with the last cell
    logic [47:0] exp_bits; // expected serial stream, first bit in the MSB
    int          exp_lat;  // clk from the last cell_valid to the latch cycle
  } vec_t;

  vec_t vt[6];

  function automatic logic [47:0] cells8(input logic [5:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction

  function automatic vec_t mkv(input string nm, input logic [47:0] c, input int n,
                               input bit fl, input logic [47:0] eb, input int lat);
    vec_t v;
    v.name     = nm;
    v.cells    = c;
    v.n        = n;
    v.fl       = fl;
    v.exp_bits = eb;
    v.exp_lat  = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cell per two clk; flush optionally rides on the last cell.
  task automatic push_cells(input logic [47:0] c, input int n, input bit fl);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      cell_in    = c[6*j +: 6];
      cell_valid = 1'b1;
      flush      = fl && (j == n - 1);
      push_cyc   = cyc;
      @(negedge clk);
      cell_valid = 1'b0;
      flush      = 1'b0;
      cell_in    = '0;
    end
  endtask

  task automatic wait_latch(input int base, input string name);
    int t = 0;
    while (latch_cnt == base && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_latch_seen"}, 64'(latch_cnt != base), 64'd1);
  endtask

  task automatic wait_busy(input string name);
    int t = 0;
    while (!busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_busy_seen"}, 64'(busy), 64'd1);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench stalled at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, l0, b0, t;
    logic [47:0] seq8;

    seq8 = cells8(6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08);
    // Full lines latch 98 clk after the last cell_valid: one clk until the
    // pop, then 96 clk of shifting plus one. Flushed lines need one extra clk
    // to notice the empty FIFO; a lone flushed cell also spends one in IDLE.
    vt[0] = mkv("full_seq", seq8, 8, 1'b0, 48'h0420C41461C8, 98);
    vt[1] = mkv("three_3f_flush", cells8(6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00),
                3, 1'b1, 48'hFFFFC0000000, 99);
    vt[2] = mkv("five_flush", cells8(6'h2A, 6'h15, 6'h3F, 6'h01, 6'h20, 6'h00, 6'h00, 6'h00),
                5, 1'b1, 48'hA95FC1800000, 99);
    vt[3] = mkv("one_flush", cells8(6'h11, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00),
                1, 1'b1, 48'h440000000000, 100);
    vt[4] = mkv("seven_flush", cells8(6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h00),
                7, 1'b1, 48'h0420C41461C0, 99);
    vt[5] = mkv("full_mixed", cells8(6'h3F, 6'h00, 6'h3F, 6'h00, 6'h21, 6'h12, 6'h0C, 6'h33),
                8, 1'b0, 48'hFC0FC0852333, 98);

    rst        = 1'b1;
    cell_in    = '0;
    cell_valid = 1'b0;
    flush      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({ready, sclk, sdo, latch, busy, overflow}), 64'(6'b100000));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outputs", 64'({ready, sclk, sdo, latch, busy, overflow}), 64'(6'b100000));

    // Whole-line vectors
    for (int i = 0; i < 6; i++) begin
      r0 = rise_cnt;
      l0 = latch_cnt;
      push_cells(vt[i].cells, vt[i].n, vt[i].fl);
      wait_latch(l0, vt[i].name);
      repeat (4) @(negedge clk);
      chk({vt[i].name, "_rises"}, 64'(rise_cnt - r0), 64'd48);
      chk({vt[i].name, "_bits"}, 64'(cap), 64'(vt[i].exp_bits));
      chk({vt[i].name, "_latency"}, 64'(latch_cyc - push_cyc), 64'(vt[i].exp_lat));
      chk({vt[i].name, "_latches"}, 64'(latch_cnt - l0), 64'd1);
      chk({vt[i].name, "_idle"}, 64'({busy, sclk, ready}), 64'(3'b001));
    end

    // Flush with nothing buffered produces no activity at all.
    r0 = rise_cnt;
    l0 = latch_cnt;
    b0 = busy_cnt;
    pulse_flush();
    repeat (20) @(negedge clk);
    chk("empty_flush_rises", 64'(rise_cnt - r0), 64'd0);
    chk("empty_flush_latches", 64'(latch_cnt - l0), 64'd0);
    chk("empty_flush_busy", 64'(busy_cnt - b0), 64'd0);

    // Ten back-to-back cells during a shift: only four fit.
    l0 = latch_cnt;
    push_cells(seq8, 8, 1'b0);
    wait_busy("ovf");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) chk("ovf_ready_at_3", 64'(ready), 64'd1);
      if (k == 4) chk("ovf_ready_at_4", 64'(ready), 64'd0);
      cell_in    = 6'h11 * 6'(k % 4 == 0) + 6'h22 * 6'(k % 4 == 1)
                 + 6'h33 * 6'(k % 4 == 2) + 6'h0C * 6'(k % 4 == 3) + 6'(k >= 4);
      cell_valid = 1'b1;
    end
    @(negedge clk);
    cell_valid = 1'b0;
    cell_in    = '0;
    chk("ovf_flag_set", 64'(overflow), 64'd1);
    wait_latch(l0, "ovf_line1");
    r0 = rise_cnt;
    l0 = latch_cnt;
    repeat (10) @(negedge clk);
    chk("ovf_ready_after_drain", 64'(ready), 64'd1);
    pulse_flush();
    wait_latch(l0, "ovf_line2");
    repeat (4) @(negedge clk);
    chk("ovf_line2_rises", 64'(rise_cnt - r0), 64'd48);
    chk("ovf_line2_bits", 64'(cap), 64'(48'h462CCC000000));
    chk("ovf_flag_sticky", 64'(overflow), 64'd1);

    // Reset in the middle of a shift aborts it without a latch.
    r0 = rise_cnt;
    l0 = latch_cnt;
    push_cells(seq8, 8, 1'b0);
    t = 0;
    while (rise_cnt - r0 < 20 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_reached_bit20", 64'(rise_cnt - r0 >= 20), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 64'({sclk, sdo, latch, busy, overflow, ready}), 64'(6'b000001));
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_latch", 64'(latch_cnt - l0), 64'd0);
    r0 = rise_cnt;
    l0 = latch_cnt;
    push_cells(vt[5].cells, 8, 1'b0);
    wait_latch(l0, "rst_after");
    repeat (4) @(negedge clk);
    chk("rst_after_rises", 64'(rise_cnt - r0), 64'd48);
    chk("rst_after_bits", 64'(cap), 64'(48'hFC0FC0852333));

    // Flush on the fifth cell, then a stray flush during the shift.
    r0 = rise_cnt;
    l0 = latch_cnt;
    push_cells(vt[2].cells, 5, 1'b1);
    wait_busy("late_flush");
    repeat (10) @(negedge clk);
    pulse_flush();
    wait_latch(l0, "late_flush");
    repeat (150) @(negedge clk);
    chk("late_flush_rises", 64'(rise_cnt - r0), 64'd48);
    chk("late_flush_bits", 64'(cap), 64'(48'hA95FC1800000));
    chk("late_flush_latches", 64'(latch_cnt - l0), 64'd1);
    chk("late_flush_idle", 64'(busy), 64'd0);

    chk("sclk_outside_shift", 64'(sclk_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
